xnor_popcount_neuron: RTL and testbench

Binary-neural-network neuron. It streams WIDTH-bit image/weight word pairs, forms the bitwise XNOR of each pair, popcounts the result and accumulates over NUM_WORDS beats. It then emits the total match count and a binary activation (count >= threshold) through a valid/ready handshake. It is the sequential, parametrised successor of the fixed 7-bit XNOR stage and sits between the feature/weight streamers and the next BNN layer.

---
 rtl/bnn_pkg.sv | 26 ++
 rtl/xnor_popcount.sv | 19 +
 rtl/xnor_popcount_neuron.sv | 109 ++++++++++
 tb/tb_xnor_popcount_neuron.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for binary-neural-network datapath blocks: neuron FSM
// states and a width-agnostic popcount helper.
package bnn_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int POP_MAX_W = 64;
    localparam int POP_CNT_W = $clog2(POP_MAX_W + 1);

    // Counts set bits among the low n bits of v; callers zero-extend narrower words.
    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v,
                                                      input int n);
        logic [POP_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (i < n) begin
                cnt = cnt + POP_CNT_W'(v[i]);
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR-popcount of one image/weight word pair: the number of
// bit positions where the +1/-1 encoded operands agree.
module xnor_popcount
    import bnn_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] pc
);

    logic [WIDTH-1:0] match;

    assign match = ~(a ^ b);
    assign pc    = CNT_W'(popcount(POP_MAX_W'(match), WIDTH));

endmodule

// File: rtl/xnor_popcount_neuron.sv
// BNN neuron: accumulates XNOR popcounts over NUM_WORDS beats, then holds the
// total and its threshold activation until the downstream layer takes it.
module xnor_popcount_neuron
    import bnn_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int NUM_WORDS = 4,
    parameter int ACC_W     = $clog2(WIDTH * NUM_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] img,
    input  logic [WIDTH-1:0] w,
    input  logic [ACC_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_act
);

    localparam int PC_W = $clog2(WIDTH + 1);
    localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic              out_act_q, out_act_d;

    logic [PC_W-1:0]   pc;
    logic [ACC_W-1:0]  sum_next;
    logic              accept;

    xnor_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (PC_W)
    ) u_xnor_popcount (
        .a  (img),
        .b  (w),
        .pc (pc)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_act   = out_act_q;

    // clear takes priority over a beat presented in the same cycle.
    assign accept   = in_valid && in_ready && !clear;
    assign sum_next = acc_q + ACC_W'(pc);

    // NOTE: every *_d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        word_cnt_d = word_cnt_q;
        out_sum_d  = out_sum_q;
        out_act_d  = out_act_q;

        unique case (state_q)
            ACCUM: begin
                if (clear) begin
                    acc_d      = '0;
                    word_cnt_d = '0;
                end else if (accept) begin
                    if (word_cnt_q == LAST_WORD) begin
                        out_sum_d  = sum_next;
                        out_act_d  = (sum_next >= thresh);
                        acc_d      = '0;
                        word_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        acc_d      = sum_next;
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
            HOLD: begin
                // A clear discards the result even if it is being accepted this cycle.
                if (clear || out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            word_cnt_q <= '0;
            out_sum_q  <= '0;
            out_act_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            word_cnt_q <= word_cnt_d;
            out_sum_q  <= out_sum_d;
            out_act_q  <= out_act_d;
        end
    end

endmodule

// File: tb/tb_xnor_popcount_neuron.sv
// Self-checking bench for xnor_popcount_neuron (WIDTH=7, NUM_WORDS=4): table
// vectors, hand-written corner sequences and random evaluations vs a bit-count model.
module tb_xnor_popcount_neuron;

    localparam int WIDTH = 7;
    localparam int NW    = 4;
    localparam int ACC_W = 5;
    localparam int BOUND = 100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] img = '0;
    logic [WIDTH-1:0] w = '0;
    logic [ACC_W-1:0] thresh = '0;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_sum;
    logic             out_act;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int m0, m1, m2, m3;
        int th;
        int es;
        int ea;
    } vec_t;

    vec_t vecs[8];

    xnor_popcount_neuron #(
        .WIDTH     (WIDTH),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .img       (img),
        .w         (w),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_act   (out_act)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Image word agreeing with wv in exactly m bit positions.
    function automatic logic [WIDTH-1:0] img_for(input logic [WIDTH-1:0] wv, input int m);
        logic [WIDTH-1:0] mask;
        mask = 7'h7f >> (WIDTH - m);
        return wv ^ ~mask;
    endfunction

    function automatic int model_matches(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i] == b[i]) n++;
        end
        return n;
    endfunction

    // Presents one beat and returns 1 ns after the edge that accepted it.
    task automatic beat(input logic [WIDTH-1:0] iv, input logic [WIDTH-1:0] wv,
                        input logic [ACC_W-1:0] th);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        img      = iv;
        w        = wv;
        thresh   = th;
        n = 0;
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic beat_m(input int m, input int th);
        logic [WIDTH-1:0] wv;
        wv = WIDTH'($urandom);
        beat(img_for(wv, m), wv, ACC_W'(th));
    endtask

    // Called 1 ns after the last beat: checks latency and result, then handshakes.
    task automatic expect_result(input string name, input int es, input int ea);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_sum"}, int'(out_sum), es);
        check({name, "_act"}, int'(out_act), ea);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        vecs[0] = '{7, 7, 7, 7, 14, 28, 1};
        vecs[1] = '{0, 0, 0, 0, 14,  0, 0};
        vecs[2] = '{7, 7, 0, 0, 14, 14, 1};
        vecs[3] = '{7, 6, 0, 0, 14, 13, 0};
        vecs[4] = '{3, 5, 2, 4, 14, 14, 1};
        vecs[5] = '{7, 7, 7, 7, 28, 28, 1};
        vecs[6] = '{0, 0, 0, 0,  0,  0, 1};
        vecs[7] = '{7, 7, 7, 6, 28, 27, 0};

        // Reset state
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_act", int'(out_act), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Match then mismatch with fixed patterns
        for (int i = 0; i < NW; i++) beat(7'h55, 7'h55, 5'd14);
        expect_result("match_all", 28, 1);
        for (int i = 0; i < NW; i++) beat(~7'h55, 7'h55, 5'd14);
        expect_result("mismatch_all", 0, 0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            beat_m(vecs[i].m0, vecs[i].th);
            beat_m(vecs[i].m1, vecs[i].th);
            beat_m(vecs[i].m2, vecs[i].th);
            beat_m(vecs[i].m3, vecs[i].th);
            expect_result($sformatf("vec%0d", i), vecs[i].es, vecs[i].ea);
        end

        // 2. thresh only matters on the last beat
        beat_m(7, 0);
        beat_m(6, 0);
        beat_m(0, 0);
        beat_m(0, 14);
        expect_result("thresh_last_beat", 13, 0);

        // 3. Backpressure: held result, in_valid ignored
        for (int i = 0; i < NW; i++) beat_m(7, 14);
        check("bp_valid", int'(out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            w        = WIDTH'($urandom);
            img      = w;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_sum", int'(out_sum), 28);
            check("bp_out_act", int'(out_act), 1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release", int'(out_valid), 0);
        for (int i = 0; i < NW; i++) beat_m(2, 14);
        expect_result("bp_fresh", 8, 0);

        // 4. Input gaps
        begin
            int vseq[7];
            int mseq[7];
            vseq = '{1, 0, 0, 1, 1, 0, 1};
            mseq = '{3, 7, 7, 5, 2, 7, 4};
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                in_valid = vseq[c][0];
                w        = WIDTH'($urandom);
                img      = img_for(w, mseq[c]);
                thresh   = 5'd14;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                if (c == 5) check("gap_no_early_valid", int'(out_valid), 0);
            end
            expect_result("gaps", 14, 1);
        end

        // 5. clear drops partial accumulation and a same-cycle beat
        beat_m(7, 14);
        beat_m(7, 14);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        w        = WIDTH'($urandom);
        img      = w;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < NW; i++) beat_m(1, 14);
        check("clr_valid", int'(out_valid), 1);
        check("clr_sum", int'(out_sum), 4);
        check("clr_act", int'(out_act), 0);
        // clear in HOLD with out_ready high
        @(negedge clk);
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clr_hold_valid", int'(out_valid), 0);
        check("clr_hold_sum_kept", int'(out_sum), 4);
        check("clr_hold_in_ready", int'(in_ready), 1);
        for (int i = 0; i < NW; i++) beat_m(5, 14);
        expect_result("clr_after", 20, 1);

        // 6. Asynchronous reset: first while holding a result, then mid-accumulation
        for (int i = 0; i < NW; i++) beat_m(7, 14);
        check("rst_hold_valid_pre", int'(out_valid), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_sum", int'(out_sum), 0);
        check("arst_out_act", int'(out_act), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) beat_m(7, 14);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) beat_m(7, 14);
        expect_result("rst_midop", 28, 1);

        // Random evaluations against the bit-count model
        for (int e = 0; e < 25; e++) begin
            int exp_sum;
            int th_last;
            int hold;
            logic [WIDTH-1:0] iv, wv;
            exp_sum = 0;
            th_last = 0;
            for (int b = 0; b < NW; b++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) @(negedge clk);
                iv      = WIDTH'($urandom);
                wv      = WIDTH'($urandom);
                th_last = int'($urandom_range(0, 31));
                exp_sum += model_matches(iv, wv);
                beat(iv, wv, ACC_W'(th_last));
            end
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) @(negedge clk);
            expect_result($sformatf("rand%0d", e), exp_sum, (exp_sum >= th_last) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
